updown_modcounter: RTL and testbench
====================================

Name: updown_modcounter

Overview:
Parametrised loadable up/down counter with programmable modulus, four terminal-count modes and an enable prescaler. Generalises the team's loadable down counter to either direction, arbitrary count range 0..M and rate-divided stepping. Provides a single-cycle terminal-count pulse for chaining and a sticky Done flag for one-shot timing. Used as the general timer/event-count primitive in datapath and control blocks.

Parameters:
N, 8, width of count, load value and modulus
PRE_W, 4, width of prescale divisor

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
R  input  N  load / auto-reload value
M  input  N  modulus limit; count range 0..M
L  input  1  synchronous load
E  input  1  count enable
Up  input  1  direction: 1 = up, 0 = down
Mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 auto-reload
Div  input  PRE_W  prescale: one step per Div+1 enabled cycles
Q  output  N  count value
TC  output  1  registered terminal-count pulse, one cycle
Done  output  1  sticky one-shot completion flag

Behaviour:
- Reset (async, high): Q=0, TC=0, Done=0, prescaler P=0. Takes effect immediately, mid-operation included.
- Priority at each rising Clock: Reset > L > step > hold.
- L=1: Q<=R, P<=0, Done<=0, TC<=0. Ignores E, Mode and Up that cycle.
- Prescaler: when E=1 and L=0, tick = (P==Div). On tick, P<=0. Otherwise P<=P+1. E=0 freezes P. Div=0 ticks every enabled cycle.
- step = E & tick & ~L & ~Done. Q changes only on step.
- Terminal condition: Up=1 -> Q>=M (covers loaded R>M). Up=0 -> Q==0.
- Non-terminal step: Q<=Q+1 (up) or Q-1 (down). Modulo 2^N arithmetic, never reached beyond terminal.
- Wrap (00): step at terminal -> Q<=0 (up) or M (down), TC<=1.
- Auto-reload (11): step at terminal -> Q<=R, TC<=1.
- Saturate (01): a step that lands Q on terminal -> TC<=1. Steps at terminal hold Q with no TC.
- One-shot (10): a step that lands Q on terminal -> TC<=1, Done<=1. Further steps are blocked until L. Reset also clears Done.
- TC: registered. High for exactly the one cycle after the qualifying edge. Cleared on every other edge. A load never produces TC.
- Up, Mode, M and Div changes are sampled each edge. They take effect on the next step, with no flush.
- M=0 up or down: Q stays 0. Wrap and reload produce TC on every step.
- Div changed below the current P: P keeps incrementing and wraps at 2^PRE_W before matching. This is accepted behaviour; L clears it.

Decomposition:
- Shared package updown_modcounter_pkg:
  - mode constants MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10, MODE_RELOAD=2'b11
  - mode typedef
- One sub-module, tick_prescaler (params PRE_W):
  - inputs Clock, Reset, clr (=L), en (=E), Div
  - output tick
  - holds P

Test Plan:
- Reset: assert Reset mid-count at Q=5, asynchronous to Clock -> Q=0, TC=0, Done=0 before the next edge; after release, counting resumes from 0.
- Wrap, up: N=8, M=9, Mode=00, Up=1, E=1, Div=0 from Q=0 -> Q counts 0..9, then 0. TC high the cycle after Q 9->0. Period of 10 cycles.
- One-shot, down: R=3, L pulse, Mode=10, Up=0, E=1 -> Q 3,2,1,0. TC and Done rise after the 1->0 edge. Q holds 0 with no further TC. A new L with R=2 clears Done and restarts.
- Prescale + reload: Div=2, Mode=11, R=5, M=7, Up=1 -> Q steps every 3rd enabled cycle, 5,6,7,5. TC on the 7->5 edge only. Dropping E for 4 cycles freezes both Q and P.
- Saturate + priority: Mode=01, Up=1, M=4, Q=3, step -> Q=4 with one TC; further steps hold 4 with no TC. L=1 and E=1 together with R=1 -> Q=1 with no TC.
- Up with R>M: load R=12, M=9, Mode=00, Up=1 -> the next step gives Q=0 and TC=1.

Source files
------------

// File: rtl/updown_modcounter_pkg.sv
// Shared types for the up/down modulus counter: terminal-count mode encoding.
package updown_modcounter_pkg;

    // Behaviour of a step taken while the count sits at its terminal value
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RELOAD  = 2'b11
    } mode_t;

endpackage : updown_modcounter_pkg

// File: rtl/updown_modcounter_if.sv
// Signal bundle between a controller (master) and the up/down modulus counter (slave).
// Interface semantics: there is no valid/ready handshake. The master holds R, M, L, E,
// Up, Mode and Div stable around each rising clock; every edge samples them.
// Q, TC and Done are registered outputs and are valid in the cycle after each edge.
interface updown_modcounter_if #(
    parameter int N     = 8,
    parameter int PRE_W = 4
);
    logic [N-1:0]     R;
    logic [N-1:0]     M;
    logic             L;
    logic             E;
    logic             Up;
    logic [1:0]       Mode;
    logic [PRE_W-1:0] Div;
    logic [N-1:0]     Q;
    logic             TC;
    logic             Done;

    modport master (
        output R, M, L, E, Up, Mode, Div,
        input  Q, TC, Done
    );

    modport slave (
        input  R, M, L, E, Up, Mode, Div,
        output Q, TC, Done
    );
endinterface : updown_modcounter_if

// File: rtl/updown_modcounter_tick_prescaler.sv
// Enable prescaler: produces one tick per div+1 enabled cycles; clr restarts the phase.
module tick_prescaler
    import updown_modcounter_pkg::*;
#(
    parameter int PRE_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] p_q;
    logic [PRE_W-1:0] p_d;

    // Next phase: clear on load, advance or restart on enabled cycles, freeze otherwise
    always_comb begin
        p_d  = p_q;
        tick = 1'b0;
        if (clr) begin
            p_d = '0;
        end else if (en) begin
            if (p_q == div) begin
                tick = 1'b1;
                p_d  = '0;
            end else begin
                // A div lowered below p_q lets p_q run on and wrap before matching
                p_d = p_q + PRE_W'(1);
            end
        end
    end

    // Phase register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) p_q <= '0;
        else       p_q <= p_d;
    end

endmodule : tick_prescaler

// File: rtl/updown_modcounter.sv
// Loadable up/down counter with modulus M, four terminal-count modes, a prescaled
// enable, a one-cycle registered TC pulse and a sticky one-shot Done flag.
module updown_modcounter
    import updown_modcounter_pkg::*;
#(
    parameter int N     = 8,
    parameter int PRE_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    updown_modcounter_if.slave bus
);

    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         done_q, done_d;

    logic         tick;
    logic         step;
    logic         at_term;
    logic         lands_term;
    logic [N-1:0] q_next;
    mode_t        mode;

    tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (bus.L),
        .en    (bus.E),
        .div   (bus.Div),
        .tick  (tick)
    );

    // Step qualification and terminal detection for the current and next count
    always_comb begin
        mode    = mode_t'(bus.Mode);
        step    = tick & ~done_q;
        q_next  = bus.Up ? (q_q + N'(1)) : (q_q - N'(1));
        // Up uses >= so a loaded value above M is treated as already terminal
        at_term    = bus.Up ? (q_q >= bus.M)    : (q_q == '0);
        lands_term = bus.Up ? (q_next >= bus.M) : (q_next == '0);
    end

    // Next count, TC pulse and Done flag: load beats step, step beats hold
    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        done_d = done_q;
        if (bus.L) begin
            q_d    = bus.R;
            done_d = 1'b0;
        end else if (step) begin
            unique case (mode)
                MODE_WRAP: begin
                    if (at_term) begin
                        q_d  = bus.Up ? '0 : bus.M;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_next;
                    end
                end
                MODE_RELOAD: begin
                    if (at_term) begin
                        q_d  = bus.R;
                        tc_d = 1'b1;
                    end else begin
                        q_d = q_next;
                    end
                end
                MODE_SAT, MODE_ONESHOT: begin
                    // Steps taken at terminal hold silently; only arriving there pulses TC
                    if (!at_term) begin
                        q_d = q_next;
                        if (lands_term) begin
                            tc_d = 1'b1;
                            if (mode == MODE_ONESHOT) done_d = 1'b1;
                        end
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Count, TC and Done registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.TC   = tc_q;
    assign bus.Done = done_q;

endmodule : updown_modcounter

// File: tb/tb_updown_modcounter.sv
// Bench for updown_modcounter: directed scenarios with literal expectations, then
// randomized stimulus, all checked every cycle against an arithmetic reference model.
module tb_updown_modcounter;

    localparam int N     = 8;
    localparam int PRE_W = 4;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    updown_modcounter_if #(.N(N), .PRE_W(PRE_W)) bus ();

    updown_modcounter #(.N(N), .PRE_W(PRE_W)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_q    = 0;
    int m_p    = 0;
    bit m_tc   = 1'b0;
    bit m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        int  q, md, mm;
        bit  term, tc_n;
        if (rst) begin
            m_q = 0; m_p = 0; m_tc = 1'b0; m_done = 1'b0;
        end else begin
            tc_n = 1'b0;
            q    = m_q;
            mm   = int'(bus.M);
            md   = int'(bus.Mode);
            if (bus.L) begin
                m_q = int'(bus.R); m_p = 0; m_done = 1'b0;
            end else if (bus.E) begin
                if (m_p == int'(bus.Div)) begin
                    m_p = 0;
                    if (!m_done) begin
                        term = bus.Up ? (q >= mm) : (q == 0);
                        if (md == 0 || md == 3) begin
                            if (term) begin
                                tc_n = 1'b1;
                                if (md == 0) q = bus.Up ? 0 : mm;
                                else         q = int'(bus.R);
                            end else begin
                                q = bus.Up ? q + 1 : q - 1;
                            end
                        end else if (!term) begin
                            q = bus.Up ? q + 1 : q - 1;
                            if (bus.Up ? (q >= mm) : (q == 0)) begin
                                tc_n = 1'b1;
                                if (md == 2) m_done = 1'b1;
                            end
                        end
                        m_q = q;
                    end
                end else begin
                    m_p = (m_p + 1) % (1 << PRE_W);
                end
            end
            m_tc = tc_n;
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_q",    int'(bus.Q),    m_q);
        chk("model_tc",   int'(bus.TC),   int'(m_tc));
        chk("model_done", int'(bus.Done), int'(m_done));
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int r, input int m, input bit l, input bit e,
                          input bit up, input int mode, input int div);
        bus.R    = N'(r);
        bus.M    = N'(m);
        bus.L    = l;
        bus.E    = e;
        bus.Up   = up;
        bus.Mode = 2'(mode);
        bus.Div  = PRE_W'(div);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string name, input int q, input int tc, input int done);
        chk({name, "_q"},    int'(bus.Q),    q);
        chk({name, "_tc"},   int'(bus.TC),   tc);
        chk({name, "_done"}, int'(bus.Done), done);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1, 0, 0);
        cyc(2);
        chk_out("reset", 0, 0, 0);
        rst = 1'b0;

        // Wrap up, M=9
        set_in(0, 9, 0, 1, 1, 0, 0);
        cyc(9);  chk_out("wrap_at9", 9, 0, 0);
        cyc(1);  chk_out("wrap_to0", 0, 1, 0);
        cyc(1);  chk_out("wrap_1",   1, 0, 0);

        // Async reset mid-count at Q=5
        cyc(4);  chk_out("pre_rst", 5, 0, 0);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        cyc(3);  chk_out("after_rst", 3, 0, 0);

        // One-shot down from 3
        set_in(3, 9, 1, 1, 0, 2, 0);
        cyc(1);  chk_out("os_load", 3, 0, 0);
        bus.L = 1'b0;
        cyc(2);  chk_out("os_1",    1, 0, 0);
        cyc(1);  chk_out("os_0",    0, 1, 1);
        cyc(1);  chk_out("os_hold", 0, 0, 1);
        cyc(3);  chk_out("os_hold2", 0, 0, 1);
        bus.R = 8'd2; bus.L = 1'b1;
        cyc(1);  chk_out("os_reload", 2, 0, 0);
        bus.L = 1'b0;
        cyc(1);  chk_out("os_restart", 1, 0, 0);

        // Prescale Div=2 with auto-reload, R=5 M=7
        set_in(5, 7, 1, 1, 1, 3, 2);
        cyc(1);  chk_out("pr_load", 5, 0, 0);
        bus.L = 1'b0;
        cyc(2);  chk_out("pr_wait", 5, 0, 0);
        cyc(1);  chk_out("pr_6",    6, 0, 0);
        cyc(1);
        bus.E = 1'b0;
        cyc(4);  chk_out("pr_frozen", 6, 0, 0);
        bus.E = 1'b1;
        cyc(1);  chk_out("pr_resume", 6, 0, 0);
        cyc(1);  chk_out("pr_7",      7, 0, 0);
        cyc(3);  chk_out("pr_reload", 5, 1, 0);
        cyc(1);  chk_out("pr_tc_off", 5, 0, 0);

        // Saturate up to M=4, then load+enable priority
        set_in(3, 4, 1, 1, 1, 1, 0);
        cyc(1);  chk_out("sat_load", 3, 0, 0);
        bus.L = 1'b0;
        cyc(1);  chk_out("sat_4",    4, 1, 0);
        cyc(1);  chk_out("sat_hold", 4, 0, 0);
        cyc(2);  chk_out("sat_hold2", 4, 0, 0);
        bus.R = 8'd1; bus.L = 1'b1;
        cyc(1);  chk_out("sat_ld_pri", 1, 0, 0);

        // Loaded R above M counting up
        set_in(12, 9, 1, 1, 1, 0, 0);
        cyc(1);  chk_out("big_load", 12, 0, 0);
        bus.L = 1'b0;
        cyc(1);  chk_out("big_wrap", 0, 1, 0);

        // M=0 wrap down: Q stays 0 with TC on every step
        set_in(0, 0, 0, 1, 0, 0, 0);
        cyc(2);  chk_out("m0_down", 0, 1, 0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.M = N'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  bus.Up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus.Mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.Div = PRE_W'($urandom_range(0, 3));
            bus.R = N'($urandom_range(0, 20));
            bus.L = ($urandom_range(0, 19) == 0);
            bus.E = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 chk_out("rnd_async_rst", 0, 0, 0);
                @(negedge clk) rst = 1'b0;
            end else begin
                cyc(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updown_modcounter
